work_dispatcher: RTL and testbench

WORK_DISPATCHER -- requirements
Module: work_dispatcher

---
 rtl/multicore_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/work_dispatcher.sv | 117 +++++++++++
 tb/tb_work_dispatcher.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// Shared constants and FSM state type for the multicore work dispatcher.
package multicore_pkg;
    localparam int MAX_CORES = 8;
    localparam int ADDR_W    = 8;

    typedef enum logic [1:0] {
        DISPATCH = 2'd0,
        DRAIN    = 2'd1,
        DONE     = 2'd2
    } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; search begins just above the last accepted grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] pend_i,
    input  logic         accept_i,
    output logic [N-1:0] gnt_o
);
    localparam logic [N-1:0] ONE = N'(1);

    // mask_q marks the cores at or above the search start; all ones means start at core 0
    logic [N-1:0] mask_q, mask_d, masked;

    assign masked = pend_i & mask_q;

    always_comb begin
        if (|masked) gnt_o = masked & (~masked + ONE);
        else         gnt_o = pend_i & (~pend_i + ONE);
    end

    // Bits strictly above the granted core; empty after the top core wraps to core 0
    assign mask_d = ~((gnt_o << 1) - ONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                 mask_q <= '1;
        else if (accept_i && |gnt_o) mask_q <= mask_d;
    end
endmodule

// File: rtl/work_dispatcher.sv
// Hands out CHUNK-sized address ranges to requesting cores, retires them once the
// 256-entry space is exhausted, and accumulates the counts the cores report back.
module work_dispatcher
    import multicore_pkg::*;
#(
    parameter int CORES = 4,
    parameter int CHUNK = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CORES-1:0]     req,
    output logic [CORES-1:0]     grant,
    output logic [ADDR_W-1:0]    range_lo,
    output logic [ADDR_W-1:0]    range_hi,
    output logic                 empty,
    input  logic [CORES-1:0]     res_strobe,
    input  logic [8*CORES-1:0]   res_data,
    output logic [15:0]          total,
    output logic [15:0]          cycle_count,
    output logic                 done
);
    state_e              state_q, state_d;
    logic [CORES-1:0]    pending_q, pending_d, retired_q, retired_d;
    logic [CORES-1:0]    grant_q, grant_d, sel;
    logic [8:0]          base_q, base_d;
    logic [ADDR_W-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic                empty_q, empty_d, done_q, done_d;
    logic [15:0]         total_q, total_d, cyc_q, cyc_d, sum;
    logic [16:0]         total_sum;
    logic                accept;

    assign accept = (state_q != DONE) && (|pending_q);

    rr_arbiter #(.N(CORES)) u_arb (
        .clk_i    (clk),
        .rst_ni   (reset),
        .pend_i   (pending_q),
        .accept_i (accept),
        .gnt_o    (sel)
    );

    always_comb begin
        sum = '0;
        for (int i = 0; i < CORES; i++)
            if (res_strobe[i]) sum = sum + {8'h00, res_data[8*i +: 8]};
        total_sum = {1'b0, total_q} + {1'b0, sum};
        total_d   = total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end

    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
        base_d    = base_q;
        grant_d   = '0;
        lo_d      = '0;
        hi_d      = '0;
        empty_d   = 1'b0;
        case (state_q)
            DISPATCH: if (|pending_q) begin
                grant_d = sel;
                lo_d    = base_q[7:0];
                hi_d    = base_q[7:0] + 8'(CHUNK - 1);
                base_d  = base_q + 9'(CHUNK);
                if (base_d[8]) state_d = DRAIN;
            end
            DRAIN: begin
                if (|pending_q) begin
                    grant_d   = sel;
                    empty_d   = 1'b1;
                    retired_d = retired_q | sel;
                end
                if (&retired_d) state_d = DONE;
            end
            default: ;
        endcase
        // A req arriving on the granting edge survives the clear
        pending_d = (pending_q & ~grant_d) | ((state_q == DONE) ? '0 : req);
        cyc_d     = (state_q != DONE && cyc_q != 16'hFFFF) ? cyc_q + 16'd1 : cyc_q;
        done_d    = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= DISPATCH;
            pending_q <= '0;
            retired_q <= '0;
            base_q    <= '0;
            grant_q   <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            empty_q   <= 1'b0;
            total_q   <= '0;
            cyc_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            retired_q <= retired_d;
            base_q    <= base_d;
            grant_q   <= grant_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            empty_q   <= empty_d;
            total_q   <= total_d;
            cyc_q     <= cyc_d;
            done_q    <= done_d;
        end
    end

    assign grant       = grant_q;
    assign range_lo    = lo_q;
    assign range_hi    = hi_q;
    assign empty       = empty_q;
    assign total       = total_q;
    assign cycle_count = cyc_q;
    assign done        = done_q;
endmodule

// File: tb/tb_work_dispatcher.sv
// Randomized bench for work_dispatcher checked against an abstract cycle model.
module tb_work_dispatcher;
    localparam int C  = 4;
    localparam int CH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [C-1:0]  req, grant, res_strobe;
    logic [7:0]    range_lo, range_hi;
    logic          empty, done;
    logic [8*C-1:0] res_data;
    logic [15:0]   total, cycle_count;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int m_pend[C];
    int m_ret[C];
    int m_last, m_base, m_mode, m_tot, m_cyc, m_done;
    int e_grant, e_lo, e_hi, e_emp;

    always #5 clk = ~clk;

    work_dispatcher #(.CORES(C), .CHUNK(CH)) dut (
        .clk(clk), .reset(reset), .req(req), .grant(grant),
        .range_lo(range_lo), .range_hi(range_hi), .empty(empty),
        .res_strobe(res_strobe), .res_data(res_data),
        .total(total), .cycle_count(cycle_count), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < C; i++) begin m_pend[i] = 0; m_ret[i] = 0; end
        m_last = C - 1; m_base = 0; m_mode = 0; m_tot = 0; m_cyc = 0; m_done = 0;
        e_grant = 0; e_lo = 0; e_hi = 0; e_emp = 0;
    endfunction

    // mode: 0 = handing out ranges, 1 = retiring cores, 2 = finished
    function automatic void model_edge(input logic [C-1:0] r, input logic [C-1:0] s,
                                       input logic [8*C-1:0] d);
        int nm, sum, k, all;
        bit found;
        nm = m_mode; found = 0;
        e_grant = 0; e_lo = 0; e_hi = 0; e_emp = 0;
        if (m_mode != 2) begin
            for (int i = 0; i < C; i++) begin
                k = (m_last + 1 + i) % C;
                if (!found && m_pend[k] != 0) begin
                    found = 1;
                    e_grant = 1 << k;
                    m_pend[k] = 0;
                    m_last = k;
                    if (m_mode == 0) begin
                        e_lo = m_base; e_hi = m_base + CH - 1;
                        m_base += CH;
                        if (m_base >= 256) nm = 1;
                    end else begin
                        e_emp = 1; m_ret[k] = 1;
                    end
                end
            end
        end
        if (m_mode == 1) begin
            all = 1;
            for (int i = 0; i < C; i++) if (m_ret[i] == 0) all = 0;
            if (all != 0) nm = 2;
        end
        if (m_mode != 2)
            for (int i = 0; i < C; i++) if (r[i]) m_pend[i] = 1;
        m_done = (m_mode == 2) ? 1 : 0;
        if (m_mode != 2 && m_cyc < 65535) m_cyc++;
        sum = 0;
        for (int i = 0; i < C; i++) if (s[i]) sum += int'(d[8*i +: 8]);
        m_tot = (m_tot + sum > 65535) ? 65535 : m_tot + sum;
        m_mode = nm;
    endfunction

    task automatic step(input logic [C-1:0] r, input logic [C-1:0] s, input logic [8*C-1:0] d);
        req = r; res_strobe = s; res_data = d;
        @(posedge clk);
        model_edge(r, s, d);
        #1;
        chk("grant", grant, e_grant);
        chk("range_lo", range_lo, e_lo);
        chk("range_hi", range_hi, e_hi);
        chk("empty", empty, e_emp);
        chk("total", total, m_tot);
        chk("cycle_count", cycle_count, m_cyc);
        chk("done", done, m_done);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_lo"}, range_lo, 0);
        chk({tag, "_hi"}, range_hi, 0);
        chk({tag, "_empty"}, empty, 0);
        chk({tag, "_total"}, total, 0);
        chk({tag, "_cyc"}, cycle_count, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // starts and ends on a falling edge; grant is watched while reset is held
    task automatic reset_dut(input string tag);
        reset = 1'b0;
        req = '0; res_strobe = '0; res_data = '0;
        model_reset();
        #1;
        check_zero(tag);
        repeat (2) begin
            @(posedge clk); #1;
            chk({tag, "_grant_in_reset"}, grant, 0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int budget;
        reset = 1'b1; req = '0; res_strobe = '0; res_data = '0;
        model_reset();
        @(negedge clk);
        reset_dut("rst");

        // four simultaneous requests are served in index order
        step(4'b1111, '0, '0);
        for (int i = 0; i < C; i++) begin
            step('0, '0, '0);
            chk("burst_grant", grant, 1 << i);
            chk("burst_lo", range_lo, 16 * i);
        end

        reset_dut("rst2");
        // single request plus two simultaneous result strobes (5 + 7)
        step(4'b0001, 4'b0011, {16'h0, 8'd7, 8'd5});
        chk("sum_5_7", total, 12);
        step('0, '0, '0);
        chk("first_grant", grant, 4'b0001);
        chk("first_lo", range_lo, 8'h00);
        chk("first_hi", range_hi, 8'h0F);
        chk("first_empty", empty, 0);

        // random traffic until every core has retired
        budget = 0;
        while (m_mode != 2 && budget < 3000) begin
            step(C'($urandom) & C'($urandom), C'($urandom), $urandom);
            budget++;
        end
        chk("reached_done", (m_mode == 2) ? 1 : 0, 1);
        repeat (4) step(C'($urandom), C'($urandom) & C'($urandom), $urandom);
        chk("done_high", done, 1);

        // drive total into saturation
        repeat (80) step('0, 4'b1111, 32'hFFFF_FFFF);
        chk("total_sat", total, 16'hFFFF);

        reset_dut("rst3");
        step(4'b0001, '0, '0);
        step('0, '0, '0);
        chk("regrant", grant, 4'b0001);
        chk("regrant_lo", range_lo, 8'h00);
        chk("regrant_hi", range_hi, 8'h0F);

        // reset lands while two requests are still waiting
        step(4'b0110, '0, '0);
        reset_dut("rst4");
        repeat (4) begin
            step('0, '0, '0);
            chk("no_stale_grant", grant, 0);
        end
        step(4'b0001, '0, '0);
        step('0, '0, '0);
        chk("post_abort_lo", range_lo, 8'h00);
        chk("post_abort_grant", grant, 4'b0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
